ifetch_unit: RTL and testbench

//  Owns the architectural PC register and fetches instructions from instruction memory via a

---
 rtl/ifetch_unit.sv | 105 ++++++++++
 tb/tb_ifetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the architectural PC, issues one fetch at a time to
// instruction memory and hands {pc, inst} to the core, loading npc when the core accepts.
module ifetch_unit #(
    parameter int unsigned          DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] npc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [DATAWIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [DATAWIDTH-1:0] imem_resp_data,
    output logic [DATAWIDTH-1:0] pc,
    output logic [DATAWIDTH-1:0] inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 fetch_misalign,
    output logic [DATAWIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;
    logic   stale;
    logic   resp_take;
    logic   accept;
    logic   npc_aligned;

    assign imem_req_addr = pc;
    assign npc_aligned   = (npc[1:0] == 2'b00);

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        resp_take      = 1'b0;
        accept         = 1'b0;
        case (state)
            S_REQ: begin
                imem_req_valid = !rst;
                if (imem_req_valid && imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response belonging to a request aborted by reset is not ours
                if (imem_resp_valid && !stale) begin
                    resp_take  = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    accept     = 1'b1;
                    state_next = npc_aligned ? S_REQ : S_HALT;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            inst           <= '0;
            inst_valid     <= 1'b0;
            fetch_misalign <= 1'b0;
            instret        <= '0;
            // A held or repeated reset must not forget a response still in flight
            stale          <= (state == S_WAIT || stale) && !imem_resp_valid;
        end else begin
            state <= state_next;
            if (imem_resp_valid && stale) begin
                stale <= 1'b0;
            end
            if (resp_take) begin
                inst       <= imem_resp_data;
                inst_valid <= 1'b1;
            end
            if (accept) begin
                instret    <= instret + DATAWIDTH'(1);
                inst_valid <= 1'b0;
                if (npc_aligned) begin
                    pc <= npc;
                end else begin
                    fetch_misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: an architectural PC/instret model predicts each retired
// {pc, inst, instret}; a pipelined memory model answers fetches with random latency.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_misalign;
    logic [31:0] instret;

    always #5 clk = ~clk;

    ifetch_unit #(.DATAWIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .npc            (npc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .pc             (pc),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .fetch_misalign (fetch_misalign),
        .instret        (instret)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] instret;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          slot;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int checks   = 0;
    int failures = 0;

    int p_req_ready  = 100;
    int p_inst_ready = 100;
    int p_spur       = 0;
    int p_branch     = 0;
    int p_misalign   = 0;
    int lat_min      = 0;
    int lat_max      = 0;
    logic [31:0] branch_at = 32'hFFFF_FFFF;
    logic [31:0] branch_to = 32'h0;

    // Architectural model: where the program should be and how much has retired
    logic [31:0] ref_pc      = RESET_PC;
    logic [31:0] ref_instret = '0;
    bit          halted      = 1'b0;
    bit          after_reset = 1'b0;
    int          stale_cnt   = 0;
    int          slot        = 0;
    int          last_deliver = 0;
    int          accepts     = 0;

    exp_t        mon_e;
    bit          hold_prev = 1'b0;
    bit          req_prev  = 1'b0;
    logic [31:0] prev_pc, prev_inst, prev_instret, prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit do_rst);
        slot++;
        rst            = do_rst;
        imem_req_ready = ($urandom_range(99) < p_req_ready);
        inst_ready     = ($urandom_range(99) < p_inst_ready);
        if (ref_pc == branch_at)
            npc = branch_to;
        else if ($urandom_range(99) < p_misalign)
            npc = ref_pc + 32'd4 + 32'($urandom_range(3, 1));
        else if ($urandom_range(99) < p_branch)
            npc = $urandom & 32'h0000_FFFC;
        else
            npc = ref_pc + 32'd4;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].slot <= slot) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
            if (stale_cnt > 0) stale_cnt--;
        end else if (mem_q.size() == 0 && $urandom_range(99) < p_spur) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
    endtask

    // Model update for the edge that follows this negedge
    task automatic observe();
        int d;
        if (after_reset) begin
            checkOutput("reset_pc", pc, RESET_PC);
            checkOutput("reset_inst", inst, 32'h0);
            checkOutput("reset_inst_valid", 32'(inst_valid), 32'h0);
            checkOutput("reset_misalign", 32'(fetch_misalign), 32'h0);
            checkOutput("reset_instret", instret, 32'h0);
            after_reset = 1'b0;
        end
        if (rst) begin
            checkOutput("req_valid_in_reset", 32'(imem_req_valid), 32'h0);
            exp_q.delete();
            ref_pc      = RESET_PC;
            ref_instret = '0;
            halted      = 1'b0;
            stale_cnt   = mem_q.size();
            after_reset = 1'b1;
            return;
        end
        if (halted) begin
            checkOutput("halt_req_valid", 32'(imem_req_valid), 32'h0);
            checkOutput("halt_misalign", 32'(fetch_misalign), 32'h1);
            checkOutput("halt_inst_valid", 32'(inst_valid), 32'h0);
            checkOutput("halt_instret", instret, ref_instret);
            return;
        end
        checkOutput("misalign_clear", 32'(fetch_misalign), 32'h0);
        if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", imem_req_addr, ref_pc);
            exp_q.push_back('{ref_pc, mem_word(ref_pc), ref_instret});
            d = slot + 1 + $urandom_range(lat_max, lat_min);
            if (d <= last_deliver) d = last_deliver + 1;
            last_deliver = d;
            mem_q.push_back('{imem_req_addr, d});
        end
        if (inst_valid && inst_ready) begin
            ref_instret = ref_instret + 32'd1;
            accepts++;
            if (npc[1:0] == 2'b00) ref_pc = npc;
            else halted = 1'b1;
        end
    endtask

    task automatic step(input bit do_rst);
        @(posedge clk);
        #1;
        applyStimulus(do_rst);
        @(negedge clk);
        observe();
    endtask

    task automatic waitAccepts(input int n, input int budget, input string name);
        int target;
        int i;
        target = accepts + n;
        i = 0;
        while (accepts < target && i < budget) begin
            step(1'b0);
            i++;
        end
        checks++;
        if (accepts < target) begin
            failures++;
            $display("[TB] FAIL %s timeout accepts=%0d required=%0d", name, accepts, target);
        end
    endtask

    // Retirement monitor: pops one prediction per accepted instruction, plus hold-stability
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev) begin
                checkOutput("hold_inst_valid", 32'(inst_valid), 32'h1);
                checkOutput("hold_pc", pc, prev_pc);
                checkOutput("hold_inst", inst, prev_inst);
                checkOutput("hold_instret", instret, prev_instret);
            end
            if (req_prev) begin
                checkOutput("req_held_valid", 32'(imem_req_valid), 32'h1);
                checkOutput("req_held_addr", imem_req_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_inst actual_pc=%h inst=%h required=none", pc, inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ret_pc", pc, mon_e.pc);
                    checkOutput("ret_inst", inst, mon_e.inst);
                    checkOutput("ret_instret", instret, mon_e.instret);
                end
            end
        end
        hold_prev    = !rst && inst_valid && !inst_ready;
        req_prev     = !rst && imem_req_valid && !imem_req_ready;
        prev_pc      = pc;
        prev_inst    = inst;
        prev_instret = instret;
        prev_addr    = imem_req_addr;
    end

    initial begin : main
        int i;
        int halt_cycles;
        step(1'b1);
        step(1'b1);

        // Straight-line fetch: addr 0 then 4, inst 0x13 at pc 0
        waitAccepts(2, 40, "t1_accepts");
        p_req_ready = 0;
        step(1'b0);
        checkOutput("t1_instret", instret, 32'd2);

        // Memory stalls the request; it must stay up with a fixed address
        for (int k = 0; k < 5; k++) step(1'b0);
        checkOutput("t2_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("t2_req_addr", imem_req_addr, 32'h8);

        // Core stalls acceptance
        p_req_ready  = 100;
        p_inst_ready = 0;
        i = 0;
        while (!inst_valid && i < 20) begin
            step(1'b0);
            i++;
        end
        for (int k = 0; k < 3; k++) step(1'b0);
        checkOutput("t3_inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("t3_pc", pc, 32'h8);
        checkOutput("t3_inst", inst, mem_word(32'h8));
        checkOutput("t3_instret", instret, 32'd2);

        // Taken branch from pc 8
        branch_at    = 32'h8;
        branch_to    = 32'h100;
        p_inst_ready = 100;
        waitAccepts(1, 20, "t4_accept");
        branch_at = 32'hFFFF_FFFF;
        step(1'b0);
        checkOutput("t4_pc", pc, 32'h100);

        // Misaligned npc halts fetch until reset
        p_misalign = 100;
        waitAccepts(1, 20, "t5_accept");
        p_misalign = 0;
        for (int k = 0; k < 3; k++) step(1'b0);
        checkOutput("t5_misalign", 32'(fetch_misalign), 32'h1);
        checkOutput("t5_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("t5_pc", pc, 32'h100);
        checkOutput("t5_instret", instret, 32'd4);
        step(1'b1);
        step(1'b0);

        // Reset while waiting on the fetch of pc 4; its late response must be dropped
        lat_min = 2;
        lat_max = 2;
        waitAccepts(1, 20, "t6_first");
        i = 0;
        while (mem_q.size() == 0 && i < 10) begin
            step(1'b0);
            i++;
        end
        step(1'b1);
        waitAccepts(1, 30, "t6_refetch");
        step(1'b0);
        checkOutput("t6_instret", instret, 32'd1);

        // Randomized traffic with spurious responses, branches, halts and resets
        lat_min      = 0;
        lat_max      = 3;
        p_req_ready  = 60;
        p_inst_ready = 50;
        p_spur       = 10;
        p_branch     = 15;
        p_misalign   = 3;
        halt_cycles  = 0;
        for (int k = 0; k < 3000; k++) begin
            halt_cycles = halted ? halt_cycles + 1 : 0;
            if (halt_cycles > 6 || (stale_cnt == 0 && $urandom_range(99) == 0))
                step(1'b1);
            else
                step(1'b0);
        end
        checkOutput("rand_progress", 32'(accepts > 100), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
